// File: rtl/stereo_window_feeder.sv
// Disparity-search producer: loads a template row (f lanes) from the left image, then
// streams the matching search strip (g beats) from the right image with backpressure.
module stereo_window_feeder #(
  parameter int PIX_W  = 3,
  parameter int WIN_W  = 16,
  parameter int WIN_H  = 16,
  parameter int MAX_D  = 64,
  parameter int IMG_W  = 128,
  parameter int ROW_AW = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [6:0]               x0,
  input  logic [ROW_AW-1:0]        y0,
  output logic                     busy,
  output logic                     mem_rd,
  output logic [ROW_AW+7:0]        mem_addr,
  input  logic [PIX_W-1:0]         mem_data,
  output logic [WIN_W*PIX_W-1:0]   f_bus,
  output logic                     f_valid,
  output logic                     row_start,
  output logic [PIX_W-1:0]         g_data,
  output logic [6:0]               g_col,
  output logic                     g_valid,
  input  logic                     g_ready,
  output logic                     work,
  output logic                     done
);

  localparam int N  = WIN_W + MAX_D - 1;
  localparam int RW = $clog2(WIN_H);
  localparam int FW = $clog2(WIN_W) + 1;
  localparam int LW = $clog2(WIN_W);
  localparam logic [6:0]    LAST_COL    = 7'(N - 1);
  localparam logic [6:0]    N_BEATS     = 7'(N);
  localparam logic [6:0]    F_LAST_LANE = 7'(WIN_W - 1);
  localparam logic [FW-1:0] F_END       = FW'(WIN_W);
  localparam logic [RW-1:0] LAST_ROW    = RW'(WIN_H - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, F_LOAD = 2'd1, G_STREAM = 2'd2, FINISH = 2'd3} state_t;

  state_t              state_r;
  logic [6:0]          x0_r;
  logic [ROW_AW-1:0]   y0_r;
  logic [RW-1:0]       row_r;
  logic [FW-1:0]       f_cnt_r;
  logic [6:0]          g_cnt_r;
  logic                busy_r, done_r, work_r, f_valid_r;
  logic [WIN_W*PIX_W-1:0] f_bus_r;
  logic                iss_v_r, iss_oob_r, ret_v_r, ret_oob_r;
  logic [6:0]          iss_off_r, ret_off_r;
  logic                mem_rd_r;
  logic [ROW_AW+7:0]   mem_addr_r;
  logic                g_valid_r, row_start_r;
  logic [PIX_W-1:0]    g_data_r;
  logic [6:0]          g_col_r;
  logic [PIX_W-1:0]    sk_data_r [2];
  logic [6:0]          sk_col_r [2];
  logic [1:0]          sk_cnt_r;

  logic                acc_s, last_acc_s, f_done_s, in_v_s, out_free_s;
  logic                iss_s, iss_side_s, iss_oob_s;
  logic [6:0]          iss_off_s, xb_s;
  logic [7:0]          iss_col_s;
  logic [RW-1:0]       row_nx_s;
  logic [ROW_AW-1:0]   yb_s, iss_row_s;
  logic [2:0]          occ_s;
  logic [PIX_W-1:0]    ret_data_s;

  // Read-issue decision: one slot per cycle; out-of-image columns take a slot but skip mem_rd.
  always_comb begin
    acc_s      = g_valid_r & g_ready;
    last_acc_s = (state_r == G_STREAM) & acc_s & (g_col_r == LAST_COL);
    f_done_s   = (state_r == F_LOAD) & ret_v_r & (ret_off_r == F_LAST_LANE);
    in_v_s     = (state_r == G_STREAM) & ret_v_r;
    out_free_s = ~g_valid_r | acc_s;
    // Credit covers output register + skid; the beat leaving this cycle frees its slot.
    occ_s      = 3'(g_valid_r) + 3'(sk_cnt_r) + 3'(iss_v_r) + 3'(ret_v_r) - 3'(acc_s);
    ret_data_s = ret_oob_r ? {PIX_W{1'b0}} : mem_data;
    iss_s      = 1'b0;
    iss_side_s = 1'b0;
    iss_off_s  = 7'd0;
    row_nx_s   = row_r;
    xb_s       = x0_r;
    yb_s       = y0_r;
    case (state_r)
      IDLE: begin
        xb_s     = x0;
        yb_s     = y0;
        row_nx_s = RW'(0);
        if (start) iss_s = 1'b1;
        else       iss_s = 1'b0;
      end
      F_LOAD: begin
        if (f_done_s) begin
          iss_s      = 1'b1;
          iss_side_s = 1'b1;
        end else if (f_cnt_r < F_END) begin
          iss_s     = 1'b1;
          iss_off_s = 7'(f_cnt_r);
        end else begin
          iss_s = 1'b0;
        end
      end
      G_STREAM: begin
        if (last_acc_s) begin
          if (row_r != LAST_ROW) begin
            iss_s    = 1'b1;
            row_nx_s = row_r + RW'(1);
          end else begin
            iss_s = 1'b0;
          end
        end else if ((g_cnt_r < N_BEATS) && (occ_s < 3'd3)) begin
          iss_s      = 1'b1;
          iss_side_s = 1'b1;
          iss_off_s  = g_cnt_r;
        end else begin
          iss_s = 1'b0;
        end
      end
      default: iss_s = 1'b0;
    endcase
    iss_col_s = {1'b0, xb_s} + {1'b0, iss_off_s};
    iss_oob_s = (iss_col_s >= 8'(IMG_W));
    iss_row_s = yb_s + ROW_AW'(row_nx_s);
  end

  // Window/row sequencing FSM with busy, done, work and f_valid strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      x0_r      <= 7'd0;
      y0_r      <= {ROW_AW{1'b0}};
      row_r     <= RW'(0);
      f_cnt_r   <= FW'(0);
      g_cnt_r   <= 7'd0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      work_r    <= 1'b0;
      f_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            x0_r    <= x0;
            y0_r    <= y0;
            row_r   <= RW'(0);
            f_cnt_r <= FW'(1);
            busy_r  <= 1'b1;
            state_r <= F_LOAD;
          end
        end
        F_LOAD: begin
          if (f_done_s) begin
            f_valid_r <= 1'b1;
            work_r    <= 1'b1;
            g_cnt_r   <= 7'd1;
            state_r   <= G_STREAM;
          end else if (iss_s) begin
            f_cnt_r <= f_cnt_r + FW'(1);
          end
        end
        G_STREAM: begin
          if (last_acc_s) begin
            f_valid_r <= 1'b0;
            work_r    <= 1'b0;
            if (row_r == LAST_ROW) begin
              done_r  <= 1'b1;
              busy_r  <= 1'b0;
              state_r <= FINISH;
            end else begin
              row_r   <= row_r + RW'(1);
              f_cnt_r <= FW'(1);
              state_r <= F_LOAD;
            end
          end else if (iss_s) begin
            g_cnt_r <= g_cnt_r + 7'd1;
          end
        end
        FINISH: begin
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  // Two-stage read tracking (issue cycle, data-return cycle) and the memory strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      iss_v_r    <= 1'b0;
      iss_off_r  <= 7'd0;
      iss_oob_r  <= 1'b0;
      ret_v_r    <= 1'b0;
      ret_off_r  <= 7'd0;
      ret_oob_r  <= 1'b0;
      mem_rd_r   <= 1'b0;
      mem_addr_r <= {(ROW_AW+8){1'b0}};
    end else begin
      iss_v_r   <= iss_s;
      iss_off_r <= iss_off_s;
      iss_oob_r <= iss_oob_s;
      ret_v_r   <= iss_v_r;
      ret_off_r <= iss_off_r;
      ret_oob_r <= iss_oob_r;
      mem_rd_r  <= iss_s & ~iss_oob_s;
      if (iss_s) mem_addr_r <= {iss_side_s, iss_row_s, iss_col_s[6:0]};
    end
  end

  // Template lanes filled from left-image returns.
  always_ff @(posedge clk) begin
    if (rst) begin
      f_bus_r <= {(WIN_W*PIX_W){1'b0}};
    end else if ((state_r == F_LOAD) && ret_v_r) begin
      f_bus_r[ret_off_r[LW-1:0]*PIX_W +: PIX_W] <= ret_data_s;
    end
  end

  // Search-beat output register backed by a 2-entry skid; skid entries are always older.
  always_ff @(posedge clk) begin
    if (rst) begin
      g_valid_r    <= 1'b0;
      g_data_r     <= {PIX_W{1'b0}};
      g_col_r      <= 7'd0;
      row_start_r  <= 1'b0;
      sk_cnt_r     <= 2'd0;
      sk_data_r[0] <= {PIX_W{1'b0}};
      sk_data_r[1] <= {PIX_W{1'b0}};
      sk_col_r[0]  <= 7'd0;
      sk_col_r[1]  <= 7'd0;
    end else if (out_free_s) begin
      if (sk_cnt_r != 2'd0) begin
        g_valid_r   <= 1'b1;
        g_data_r    <= sk_data_r[0];
        g_col_r     <= sk_col_r[0];
        row_start_r <= (sk_col_r[0] == 7'd0);
        if (sk_cnt_r == 2'd2) begin
          sk_data_r[0] <= sk_data_r[1];
          sk_col_r[0]  <= sk_col_r[1];
          if (in_v_s) begin
            sk_data_r[1] <= ret_data_s;
            sk_col_r[1]  <= ret_off_r;
            sk_cnt_r     <= 2'd2;
          end else begin
            sk_cnt_r <= 2'd1;
          end
        end else if (in_v_s) begin
          sk_data_r[0] <= ret_data_s;
          sk_col_r[0]  <= ret_off_r;
          sk_cnt_r     <= 2'd1;
        end else begin
          sk_cnt_r <= 2'd0;
        end
      end else if (in_v_s) begin
        g_valid_r   <= 1'b1;
        g_data_r    <= ret_data_s;
        g_col_r     <= ret_off_r;
        row_start_r <= (ret_off_r == 7'd0);
      end else begin
        g_valid_r   <= 1'b0;
        row_start_r <= 1'b0;
      end
    end else if (in_v_s) begin
      if (sk_cnt_r == 2'd0) begin
        sk_data_r[0] <= ret_data_s;
        sk_col_r[0]  <= ret_off_r;
      end else begin
        sk_data_r[1] <= ret_data_s;
        sk_col_r[1]  <= ret_off_r;
      end
      sk_cnt_r <= sk_cnt_r + 2'd1;
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign work      = work_r;
  assign f_valid   = f_valid_r;
  assign f_bus     = f_bus_r;
  assign mem_rd    = mem_rd_r;
  assign mem_addr  = mem_addr_r;
  assign g_valid   = g_valid_r;
  assign g_data    = g_data_r;
  assign g_col     = g_col_r;
  assign row_start = row_start_r;

endmodule

// File: tb/tb_stereo_window_feeder.sv
// Scoreboard bench for stereo_window_feeder: reference lists of reads and beats are built
// from image formulas when a window starts; negedge monitors pop and compare.
module tb_stereo_window_feeder;
  localparam int PIX_W = 3, WIN_W = 16, WIN_H = 16, MAX_D = 64, IMG_W = 128, ROW_AW = 8;
  localparam int N = WIN_W + MAX_D - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst, start, g_ready;
  logic [6:0]             x0;
  logic [ROW_AW-1:0]      y0;
  logic                   busy, mem_rd, f_valid, row_start, g_valid, work, done;
  logic [ROW_AW+7:0]      mem_addr;
  logic [PIX_W-1:0]       mem_data = 3'd0;
  logic [WIN_W*PIX_W-1:0] f_bus;
  logic [PIX_W-1:0]       g_data;
  logic [6:0]             g_col;

  stereo_window_feeder dut (
    .clk(clk), .rst(rst), .start(start), .x0(x0), .y0(y0), .busy(busy),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
    .f_bus(f_bus), .f_valid(f_valid), .row_start(row_start),
    .g_data(g_data), .g_col(g_col), .g_valid(g_valid), .g_ready(g_ready),
    .work(work), .done(done)
  );

  typedef struct {
    logic [2:0]  data;
    logic [6:0]  col;
    logic        rs;
    logic [47:0] fb;
  } beat_t;

  beat_t       beat_q[$];
  logic [15:0] addr_q[$];
  int total = 0, bad = 0, done_cnt = 0, beats_acc = 0;
  bit ready_rand = 1'b0;

  function automatic logic [2:0] pix(input int side, input int x, input int y);
    return side != 0 ? 3'((3 * x + y) % 8) : 3'((x + y) % 8);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Left image (x+y)%8, right image (3x+y)%8, data one cycle after mem_rd
  always @(posedge clk)
    if (mem_rd) mem_data <= pix(int'(mem_addr[15]), int'(mem_addr[6:0]), int'(mem_addr[14:7]));

  task automatic push_window(input int x, input int y);
    for (int r = 0; r < WIN_H; r++) begin
      int row;
      logic [47:0] fb;
      row = (y + r) % 256;
      fb = '0;
      for (int i = 0; i < WIN_W; i++)
        if (x + i < IMG_W) begin
          fb[i*3 +: 3] = pix(0, x + i, row);
          addr_q.push_back({1'b0, 8'(row), 7'(x + i)});
        end
      for (int k = 0; k < N; k++) begin
        beat_t b;
        b.data = (x + k < IMG_W) ? pix(1, x + k, row) : 3'd0;
        b.col  = 7'(k);
        b.rs   = (k == 0);
        b.fb   = fb;
        beat_q.push_back(b);
        if (x + k < IMG_W) addr_q.push_back({1'b1, 8'(row), 7'(x + k)});
      end
    end
  endtask

  // Consumer ready: held high or random per cycle
  initial begin
    g_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1 g_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  bit         prev_stall = 1'b0;
  logic [2:0] prev_data;
  logic [6:0] prev_col;
  logic       prev_rs;

  initial forever begin
    @(negedge clk);
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", g_valid, 1'b1);
        chk("hold_data", g_data, prev_data);
        chk("hold_col", g_col, prev_col);
        chk("hold_row_start", row_start, prev_rs);
      end
      if (g_valid && g_ready) begin
        beats_acc++;
        if (beat_q.size() == 0) begin
          total++; bad++;
          $display("FAIL beat_extra: got col %0d want no beat", g_col);
        end else begin
          beat_t b;
          b = beat_q.pop_front();
          chk("g_data", g_data, b.data);
          chk("g_col", g_col, b.col);
          chk("row_start", row_start, b.rs);
          chk("f_bus", f_bus, b.fb);
          chk("f_valid_in_stream", f_valid, 1'b1);
          chk("work_in_stream", work, 1'b1);
        end
      end
      if (mem_rd) begin
        if (addr_q.size() == 0) begin
          total++; bad++;
          $display("FAIL rd_extra: got addr %0h want no read", mem_addr);
        end else begin
          chk("mem_addr", mem_addr, addr_q.pop_front());
        end
        chk("f_valid_vs_side", f_valid, mem_addr[15]);
      end
      if (done) begin
        done_cnt++;
        chk("done_beats_left", beat_q.size(), 0);
        chk("done_reads_left", addr_q.size(), 0);
        chk("done_busy", busy, 1'b0);
      end
      prev_stall = g_valid && !g_ready;
      prev_data  = g_data;
      prev_col   = g_col;
      prev_rs    = row_start;
    end
  end

  task automatic go(input int x, input int y);
    start = 1'b1;
    x0 = 7'(x);
    y0 = 8'(y);
    push_window(x, y);
    @(posedge clk);
    #1 start = 1'b0;
    chk("busy_after_start", busy, 1'b1);
  endtask

  task automatic wait_done(input bit spurious);
    int n = 0;
    while (!done && n < 12000) begin
      @(posedge clk);
      #1 start = 1'b0;
      if (spurious && !done && $urandom_range(0, 29) == 0) begin
        start = 1'b1;
        x0 = 7'($urandom_range(0, 127));
        y0 = 8'($urandom_range(0, 255));
      end
      n++;
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL done_timeout: got no done want done within %0d cycles", n);
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_busy"}, busy, 1'b0);
    chk({nm, "_mem_rd"}, mem_rd, 1'b0);
    chk({nm, "_mem_addr"}, mem_addr, 16'd0);
    chk({nm, "_f_bus"}, f_bus, 48'd0);
    chk({nm, "_f_valid"}, f_valid, 1'b0);
    chk({nm, "_row_start"}, row_start, 1'b0);
    chk({nm, "_g_valid"}, g_valid, 1'b0);
    chk({nm, "_g_data"}, g_data, 3'd0);
    chk({nm, "_g_col"}, g_col, 7'd0);
    chk({nm, "_work"}, work, 1'b0);
    chk({nm, "_done"}, done, 1'b0);
  endtask

  initial begin
    int base, n, dc;
    rst = 1'b1; start = 1'b0; x0 = 7'd0; y0 = 8'd0;
    repeat (3) @(posedge clk);
    #1 chk_all_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic window, consumer always ready
    go(10, 2);
    wait_done(1'b0);
    @(posedge clk); #1;

    // Same window with backpressure
    ready_rand = 1'b1;
    go(10, 2);
    wait_done(1'b0);
    @(posedge clk); #1;

    // Right edge of image, spurious starts while busy
    go(100, 0);
    wait_done(1'b1);
    start = 1'b1; x0 = 7'd50; y0 = 8'd60;
    @(posedge clk);
    #1 start = 1'b0;
    chk("start_in_done_ignored", busy, 1'b0);

    // Start the cycle after done; row address wraps
    go(5, 250);
    wait_done(1'b1);
    @(posedge clk); #1;

    // Abort in G_STREAM of row 5
    ready_rand = 1'b0;
    base = beats_acc;
    go(7, 9);
    n = 0;
    while (beats_acc - base < 5 * N + 10 && n < 12000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("abort_in_stream", work, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1 chk_all_zero("abort");
    rst = 1'b0;
    beat_q.delete();
    addr_q.delete();
    dc = done_cnt;
    repeat (40) @(posedge clk);
    #1 chk("no_done_after_abort", done_cnt, dc);
    chk("idle_after_abort", busy, 1'b0);

    // Fresh window after abort
    ready_rand = 1'b1;
    go(3, 40);
    wait_done(1'b0);
    repeat (3) @(posedge clk);
    #1 chk("done_count", done_cnt, 5);
    chk("queues_drained", beat_q.size() + addr_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
